prefetch_mem_arbiter: RTL and testbench

Shares the single cache-refill memory read port between demand-miss fills and next-line prefetch fills produced by the prefetch buffer logic. It queues prefetch block addresses in a small deduplicating FIFO and gives demand misses priority, with a starvation guard for prefetches. It tracks exactly one outstanding memory transaction and reports its completion to the requester that owns it. It sits between the cache/prefetcher and the memory interface.

---
 rtl/prefetch_mem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_prefetch_mem_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_mem_arbiter.sv
// Refill read-port arbiter: demand misses versus queued next-line prefetches,
// with a deduplicating prefetch FIFO, demand absorb and a starvation guard.
module prefetch_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int BLOCK_OFFSET = 4,
  parameter int PF_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_dm_req,
  input  logic [ADDR_W-1:0] i_dm_addr,
  output logic              o_dm_ack,
  output logic              o_dm_done,
  input  logic              i_pf_req,
  input  logic [ADDR_W-1:0] i_pf_addr,
  output logic              o_pf_full,
  output logic              o_pf_drop,
  output logic              o_pf_done,
  output logic [ADDR_W-1:0] o_pf_done_addr,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid
);
  localparam int BLK_W = ADDR_W - BLOCK_OFFSET;
  localparam int PTR_W = $clog2(PF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PF_DEPTH);
  localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  logic [PF_DEPTH-1:0] r_valid;
  logic [BLK_W-1:0]    r_blk [PF_DEPTH];
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;
  logic [STV_W-1:0]    r_starve;
  state_t              r_state;
  logic                r_owner_pf;
  logic [BLK_W-1:0]    r_cur_blk;
  logic                r_mem_req;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_dm_done;
  logic                r_pf_done;
  logic [ADDR_W-1:0]   r_pf_done_addr;
  logic                r_pf_drop;

  logic [BLK_W-1:0]    w_dm_blk;
  logic [BLK_W-1:0]    w_pf_blk;
  logic [BLK_W-1:0]    w_head_blk;
  logic                w_empty;
  logic                w_full;
  logic                w_head_valid;
  logic                w_any_valid;
  logic                w_pop_inv;
  logic                w_sel_dm;
  logic                w_sel_pf;
  logic                w_pop;
  logic                w_push;
  logic                w_pf_hit;
  logic [PF_DEPTH-1:0] w_absorb;
  logic [PF_DEPTH-1:0] w_valid_nxt;
  logic [CNT_W-1:0]    w_count_nxt;
  logic                w_unused;

  assign w_dm_blk     = i_dm_addr[ADDR_W-1:BLOCK_OFFSET];
  assign w_pf_blk     = i_pf_addr[ADDR_W-1:BLOCK_OFFSET];
  assign w_head_blk   = r_blk[r_head];
  assign w_empty      = (r_count == {CNT_W{1'b0}});
  assign w_full       = (r_count == DEPTH_C);
  assign w_head_valid = r_valid[r_head];
  assign w_any_valid  = |r_valid;
  assign w_unused     = ^{i_dm_addr[BLOCK_OFFSET-1:0], i_pf_addr[BLOCK_OFFSET-1:0]};

  // IDLE selection: invalidated heads are retired first, then demand vs prefetch.
  always_comb begin
    w_pop_inv = 1'b0;
    w_sel_dm  = 1'b0;
    w_sel_pf  = 1'b0;
    if (r_state == S_IDLE) begin
      if (!w_empty && !w_head_valid) begin
        w_pop_inv = 1'b1;
      end else if (i_dm_req && !((r_starve == LIMIT_C) && w_head_valid)) begin
        w_sel_dm = 1'b1;
      end else if (w_head_valid) begin
        w_sel_pf = 1'b1;
      end else begin
        w_sel_pf = 1'b0;
      end
    end else begin
      w_sel_dm = 1'b0;
    end
  end

  // Duplicate detection covers the FIFO, the in-flight block and a demand accepted now.
  always_comb begin
    w_pf_hit = ((r_state != S_IDLE) && (r_cur_blk == w_pf_blk)) ||
               (w_sel_dm && (w_dm_blk == w_pf_blk));
    for (int i = 0; i < PF_DEPTH; i++) begin
      w_pf_hit    = w_pf_hit | (r_valid[i] && (r_blk[i] == w_pf_blk));
      w_absorb[i] = w_sel_dm && r_valid[i] && (r_blk[i] == w_dm_blk);
    end
  end

  assign w_pop  = w_pop_inv | w_sel_pf;
  assign w_push = i_pf_req && !w_full && !w_pf_hit;

  // Next valid vector: absorb, then pop, then push.
  always_comb begin
    w_valid_nxt           = r_valid & ~w_absorb;
    w_valid_nxt[r_head]   = w_valid_nxt[r_head] & ~w_pop;
    w_valid_nxt[r_tail]   = w_valid_nxt[r_tail] | w_push;
    w_count_nxt           = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  // Prefetch FIFO storage, pointers, drop pulse and starvation counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid   <= {PF_DEPTH{1'b0}};
      r_head    <= {PTR_W{1'b0}};
      r_tail    <= {PTR_W{1'b0}};
      r_count   <= {CNT_W{1'b0}};
      r_starve  <= {STV_W{1'b0}};
      r_pf_drop <= 1'b0;
      for (int i = 0; i < PF_DEPTH; i++) begin
        r_blk[i] <= {BLK_W{1'b0}};
      end
    end else begin
      r_valid   <= w_valid_nxt;
      r_count   <= w_count_nxt;
      r_pf_drop <= i_pf_req && !w_push;
      if (w_push) begin
        r_blk[r_tail] <= w_pf_blk;
        r_tail        <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      if (w_sel_pf || (w_count_nxt == {CNT_W{1'b0}})) begin
        r_starve <= {STV_W{1'b0}};
      end else if (w_sel_dm && w_any_valid && (r_starve != LIMIT_C)) begin
        r_starve <= r_starve + STV_W'(1);
      end
    end
  end

  // Transaction FSM: one outstanding read, completion routed to its owner.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_owner_pf     <= 1'b0;
      r_cur_blk      <= {BLK_W{1'b0}};
      r_mem_req      <= 1'b0;
      r_mem_addr     <= {ADDR_W{1'b0}};
      r_dm_done      <= 1'b0;
      r_pf_done      <= 1'b0;
      r_pf_done_addr <= {ADDR_W{1'b0}};
    end else begin
      r_dm_done <= 1'b0;
      r_pf_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_sel_dm || w_sel_pf) begin
            r_owner_pf <= w_sel_pf;
            r_cur_blk  <= w_sel_pf ? w_head_blk : w_dm_blk;
            r_mem_req  <= 1'b1;
            r_mem_addr <= {(w_sel_pf ? w_head_blk : w_dm_blk), {BLOCK_OFFSET{1'b0}}};
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i_mem_gnt) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= {ADDR_W{1'b0}};
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_mem_rvalid) begin
            r_dm_done <= ~r_owner_pf;
            r_pf_done <= r_owner_pf;
            if (r_owner_pf) begin
              r_pf_done_addr <= {r_cur_blk, {BLOCK_OFFSET{1'b0}}};
            end
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_dm_ack       = w_sel_dm & i_rst_n;
  assign o_dm_done      = r_dm_done;
  assign o_pf_full      = w_full;
  assign o_pf_drop      = r_pf_drop;
  assign o_pf_done      = r_pf_done;
  assign o_pf_done_addr = r_pf_done_addr;
  assign o_mem_req      = r_mem_req;
  assign o_mem_addr     = r_mem_addr;

endmodule

// File: tb/tb_prefetch_mem_arbiter.sv
// Scoreboard bench for prefetch_mem_arbiter: expected memory addresses and
// completions are queued as stimulus is driven and checked as they appear.
module tb_prefetch_mem_arbiter;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dm_req = 1'b0;
  logic [AW-1:0] dm_addr = 32'h0;
  logic          pf_req = 1'b0;
  logic [AW-1:0] pf_addr = 32'h0;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic          dm_ack, dm_done, pf_full, pf_drop, pf_done, mem_req;
  logic [AW-1:0] pf_done_addr, mem_addr;

  prefetch_mem_arbiter #(
    .ADDR_W(AW), .BLOCK_OFFSET(4), .PF_DEPTH(4), .STARVE_LIMIT(2)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_dm_req(dm_req), .i_dm_addr(dm_addr), .o_dm_ack(dm_ack), .o_dm_done(dm_done),
    .i_pf_req(pf_req), .i_pf_addr(pf_addr), .o_pf_full(pf_full), .o_pf_drop(pf_drop),
    .o_pf_done(pf_done), .o_pf_done_addr(pf_done_addr),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic is_pf; logic [AW-1:0] addr; } done_t;
  logic [AW-1:0] exp_mem_q[$];
  done_t         exp_done_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;
  bit gnt_en = 1'b0;
  int rv_delay = 2;
  int rv_cnt = 0;

  // Memory model plus scoreboard; everything here happens on the falling edge.
  always @(negedge clk) begin
    logic [AW-1:0] em;
    done_t ed;
    mem_rvalid = 1'b0;
    mem_gnt = gnt_en;
    if (rv_cnt != 0) begin
      rv_cnt = rv_cnt - 1;
      if (rv_cnt == 0) mem_rvalid = 1'b1;
    end else if (mem_req && mem_gnt) begin
      rv_cnt = rv_delay;
    end
    if (mem_req && mem_gnt) begin
      n_cmp++;
      if (exp_mem_q.size() == 0) begin
        n_err++;
        $display("FAIL mem_issue: got addr 0x%08h, required no request", mem_addr);
      end else begin
        em = exp_mem_q.pop_front();
        if (mem_addr !== em) begin
          n_err++;
          $display("FAIL mem_issue: got addr 0x%08h, required 0x%08h", mem_addr, em);
        end
      end
    end
    if (dm_done || pf_done) begin
      done_seen++;
      n_cmp++;
      if (exp_done_q.size() == 0) begin
        n_err++;
        $display("FAIL done: got dm_done=%0b pf_done=%0b, required no completion", dm_done, pf_done);
      end else begin
        ed = exp_done_q.pop_front();
        if (pf_done !== ed.is_pf || dm_done !== !ed.is_pf ||
            (ed.is_pf && pf_done_addr !== ed.addr)) begin
          n_err++;
          $display("FAIL done: got dm=%0b pf=%0b addr=0x%08h, required pf=%0b addr=0x%08h",
                   dm_done, pf_done, pf_done_addr, ed.is_pf, ed.addr);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pf(input logic [AW-1:0] a, output logic drop_obs);
    pf_req = 1'b1;
    pf_addr = a;
    tick();
    pf_req = 1'b0;
    drop_obs = pf_drop;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (exp_mem_q.size() == 0 && exp_done_q.size() == 0 && !mem_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    tick();
  endtask

  task automatic demand_seq(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                            input int n, output bit ok);
    ok = 1'b1;
    dm_req = 1'b1;
    for (int k = 0; k < n; k++) begin
      bit got = 1'b0;
      dm_addr = base + 32'(k) * stride;
      for (int t = 0; t < 300 && !got; t++) begin
        @(negedge clk);
        got = dm_ack;
        tick();
      end
      if (!got) ok = 1'b0;
    end
    dm_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    #2;
    outs = {dm_ack, dm_done, pf_full, pf_drop, pf_done, mem_req, |pf_done_addr, |mem_addr};
    n_cmp++;
    if (outs !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: got 0x%02h, required 0x00", outs);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_demand_latency();
    bit ok;
    gnt_en = 1'b1;
    rv_delay = 1;
    tick(); tick();
    exp_mem_q.push_back(32'h0000_7000);
    exp_done_q.push_back({1'b0, 32'h0000_7000});
    dm_req = 1'b1;
    dm_addr = 32'h0000_7004;
    @(negedge clk);
    n_cmp++;
    if (dm_ack !== 1'b1) begin
      n_err++;
      $display("FAIL dm_ack_comb: got %0b, required 1", dm_ack);
    end
    tick();
    dm_req = 1'b0;
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_7000) begin
      n_err++;
      $display("FAIL mem_req_latency: got req=%0b addr=0x%08h, required req=1 addr=0x00007000", mem_req, mem_addr);
    end
    n_cmp++;
    if (dm_ack !== 1'b0) begin
      n_err++;
      $display("FAIL dm_ack_pulse: got %0b, required 0", dm_ack);
    end
    drain(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL latency_drain: got timeout, required drained"); end
  endtask

  task automatic test_prefetch_only();
    bit ok;
    logic d0, d1;
    rv_delay = 2;
    exp_mem_q.push_back(32'h0000_1000);
    exp_mem_q.push_back(32'h0000_1010);
    exp_done_q.push_back({1'b1, 32'h0000_1000});
    exp_done_q.push_back({1'b1, 32'h0000_1010});
    push_pf(32'h0000_1000, d0);
    push_pf(32'h0000_1010, d1);
    n_cmp++;
    if ({d0, d1} !== 2'b00) begin
      n_err++;
      $display("FAIL pf_only_drop: got %b, required 00", {d0, d1});
    end
    drain(ok);
    n_cmp++;
    if (!ok || pf_full !== 1'b0) begin
      n_err++;
      $display("FAIL pf_only_drain: got ok=%0b full=%0b, required ok=1 full=0", ok, pf_full);
    end
  endtask

  task automatic test_dedup_full();
    logic d;
    gnt_en = 1'b0;
    rv_delay = 2;
    tick(); tick();
    exp_mem_q.push_back(32'h0000_2000);
    exp_done_q.push_back({1'b1, 32'h0000_2000});
    for (int i = 0; i < 4; i++) begin
      exp_mem_q.push_back(32'h0000_5000 + 32'(i) * 32'h10);
      exp_done_q.push_back({1'b1, 32'h0000_5000 + 32'(i) * 32'h10});
    end
    push_pf(32'h0000_2004, d);
    n_cmp++;
    if (d !== 1'b0) begin n_err++; $display("FAIL dedup_first: got drop=%0b, required 0", d); end
    push_pf(32'h0000_2008, d);
    n_cmp++;
    if (d !== 1'b1) begin n_err++; $display("FAIL dedup_second: got drop=%0b, required 1", d); end
    for (int i = 0; i < 4; i++) begin
      push_pf(32'h0000_5000 + 32'(i) * 32'h10, d);
      n_cmp++;
      if (d !== 1'b0) begin n_err++; $display("FAIL fill_push%0d: got drop=%0b, required 0", i, d); end
    end
    n_cmp++;
    if (pf_full !== 1'b1) begin n_err++; $display("FAIL full_flag: got %0b, required 1", pf_full); end
    push_pf(32'h0000_5040, d);
    n_cmp++;
    if (d !== 1'b1 || pf_full !== 1'b1) begin
      n_err++;
      $display("FAIL full_drop: got drop=%0b full=%0b, required drop=1 full=1", d, pf_full);
    end
  endtask

  task automatic test_full_pop();
    bit ok;
    bit seen = 1'b0;
    gnt_en = 1'b1;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      seen = pf_done;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL full_pop_wait: got no pf_done, required pf_done");
    end else begin
      pf_req = 1'b1;
      pf_addr = 32'h0000_5040;
      tick();
      pf_req = 1'b0;
      n_cmp++;
      if (pf_drop !== 1'b1 || pf_full !== 1'b0) begin
        n_err++;
        $display("FAIL full_pop: got drop=%0b full=%0b, required drop=1 full=0", pf_drop, pf_full);
      end
    end
    drain(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL full_pop_drain: got timeout, required drained"); end
  endtask

  task automatic test_starvation();
    bit ok;
    logic d0, d1;
    gnt_en = 1'b0;
    rv_delay = 1;
    tick(); tick();
    exp_mem_q.push_back(32'h0000_2F00);
    exp_mem_q.push_back(32'h0000_8000);
    exp_mem_q.push_back(32'h0000_8100);
    exp_mem_q.push_back(32'h0000_3000);
    exp_mem_q.push_back(32'h0000_8200);
    exp_done_q.push_back({1'b1, 32'h0000_2F00});
    exp_done_q.push_back({1'b0, 32'h0000_8000});
    exp_done_q.push_back({1'b0, 32'h0000_8100});
    exp_done_q.push_back({1'b1, 32'h0000_3000});
    exp_done_q.push_back({1'b0, 32'h0000_8200});
    push_pf(32'h0000_2F00, d0);
    push_pf(32'h0000_3000, d1);
    n_cmp++;
    if ({d0, d1} !== 2'b00) begin n_err++; $display("FAIL starve_push: got %b, required 00", {d0, d1}); end
    gnt_en = 1'b1;
    demand_seq(32'h0000_8000, 32'h0000_0100, 3, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL starve_acks: got missing dm_ack, required 3 acks"); end
    drain(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL starve_drain: got timeout, required drained"); end
  endtask

  task automatic test_absorb();
    bit ok;
    logic d0, d1, d2;
    int done0;
    gnt_en = 1'b0;
    rv_delay = 2;
    tick(); tick();
    done0 = done_seen;
    exp_mem_q.push_back(32'h0000_4100);
    exp_mem_q.push_back(32'h0000_4000);
    exp_mem_q.push_back(32'h0000_4010);
    exp_done_q.push_back({1'b1, 32'h0000_4100});
    exp_done_q.push_back({1'b0, 32'h0000_4000});
    exp_done_q.push_back({1'b1, 32'h0000_4010});
    push_pf(32'h0000_4100, d0);
    push_pf(32'h0000_4000, d1);
    push_pf(32'h0000_4010, d2);
    n_cmp++;
    if ({d0, d1, d2} !== 3'b000) begin n_err++; $display("FAIL absorb_push: got %b, required 000", {d0, d1, d2}); end
    gnt_en = 1'b1;
    demand_seq(32'h0000_4008, 32'h0, 1, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL absorb_ack: got no dm_ack, required ack"); end
    drain(ok);
    n_cmp++;
    if (!ok || done_seen - done0 != 3) begin
      n_err++;
      $display("FAIL absorb_done: got ok=%0b completions=%0d, required ok=1 completions=3", ok, done_seen - done0);
    end
  endtask

  task automatic test_reset_wait();
    logic [7:0] outs;
    bit seen = 1'b0;
    int done0;
    gnt_en = 1'b1;
    rv_delay = 4;
    tick(); tick();
    exp_mem_q.push_back(32'h0000_6000);
    exp_done_q.push_back({1'b1, 32'h0000_6000});
    pf_req = 1'b1;
    pf_addr = 32'h0000_6000;
    tick();
    pf_req = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      tick();
      seen = mem_req;
    end
    tick();
    rst_n = 1'b0;
    #1;
    outs = {dm_ack, dm_done, pf_full, pf_drop, pf_done, mem_req, |pf_done_addr, |mem_addr};
    n_cmp++;
    if (!seen || outs !== 8'h00) begin
      n_err++;
      $display("FAIL reset_in_wait: got seen=%0b outs=0x%02h, required seen=1 outs=0x00", seen, outs);
    end
    exp_done_q.delete();
    done0 = done_seen;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) tick();
    n_cmp++;
    if (done_seen != done0) begin
      n_err++;
      $display("FAIL reset_lost_return: got %0d completions, required 0", done_seen - done0);
    end
  endtask

  initial begin
    test_reset();
    test_demand_latency();
    test_prefetch_only();
    test_dedup_full();
    test_full_pop();
    test_starvation();
    test_absorb();
    test_reset_wait();
    n_cmp++;
    if (exp_mem_q.size() != 0 || exp_done_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: got mem=%0d done=%0d pending, required 0", exp_mem_q.size(), exp_done_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
